// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with optional parity, 1 or 2 stop bits and a
// show-ahead receive FIFO read through a valid/ready handshake.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              uart_clk,
  input  logic                              rst_n,
  input  logic                              rx_enable,
  input  logic                              rx,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_perr,
  output logic                              rx_ferr,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = DATA_BITS + 2;

  localparam logic [CntW-1:0] HalfM1   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullM1   = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);
  localparam logic            LastStop = (STOP_BITS == 2);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  stop_q, stop_d;
  logic                  bit_end, push;
  logic [EntW-1:0]       push_entry, head;

  logic [EntW-1:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  full, do_push, do_pop;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM and datapath registers.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stop_q  <= stop_d;
    end
  end

  assign bit_end = (cnt_q == FullM1);
  // Entry written at the final stop sample includes that sample's framing result.
  assign push_entry = {ferr_q | ~rx_s_q, perr_q, shift_q};

  // Next-state logic: mid-bit sampling, LSB-first shift into the top of shift_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_enable && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          if (!rx_s_q) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          perr_d  = (rx_s_q != ((^shift_q) ^ ParOdd));
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_s_q;
          if (stop_q == LastStop) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves that cycle.
  always_comb begin
    rx_valid  = (level_q != '0);
    full      = (level_q == LvlW'(FIFO_DEPTH));
    do_pop    = rx_valid && rx_ready;
    do_push   = push && (!full || do_pop);
    overrun_d = push && full && !do_pop;
    wr_ptr_d  = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // FIFO pointers, level and overrun pulse.
  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge uart_clk) begin
    if (rst_n && do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_perr    = rx_valid & head[DATA_BITS];
  assign rx_ferr    = rx_valid & head[DATA_BITS+1];
  assign overrun    = overrun_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: a default 8N1 receiver (a) and an 8E2 receiver (b).
// Expected FIFO entries are queued when frames are issued; a monitor pops and
// compares whenever a DUT hands an entry over on rx_valid && rx_ready.
module tb_uart_rx_os;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_enable = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rand_rdy = 1'b0;

  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b, valid_a, valid_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;
  logic [2:0] level_a, level_b;

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  int exp_ovr_a = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) u_dut_a (
    .uart_clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx(rx_a),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_valid(valid_a),
    .rx_ready(rx_ready), .overrun(ovr_a), .fifo_level(level_a), .busy(busy_a)
  );

  uart_rx_os #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2),
    .FIFO_DEPTH(4)
  ) u_dut_b (
    .uart_clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx(rx_b),
    .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b), .rx_valid(valid_b),
    .rx_ready(rx_ready), .overrun(ovr_b), .fifo_level(level_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handed-over entry against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a && rx_ready) begin
        if (exp_a.size() == 0) check("a_unexpected_entry", {ferr_a, perr_a, data_a}, 32'hffff);
        else check("a_entry", {ferr_a, perr_a, data_a}, exp_a.pop_front());
      end
      if (valid_b && rx_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_entry", {ferr_b, perr_b, data_b}, 32'hffff);
        else check("b_entry", {ferr_b, perr_b, data_b}, exp_b.pop_front());
      end
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  // Random consumer back-pressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic drive_bit(input bit which, input logic b);
    @(posedge clk);
    #1;
    if (which) rx_b = b;
    else rx_a = b;
    repeat (OS - 1) @(posedge clk);
  endtask

  // Start, data LSB first, [parity], stop bit(s), then one idle bit.
  task automatic send(input bit which, input logic [7:0] d, input logic par,
                      input logic [1:0] stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (which) begin
      bits.push_back(par);
      bits.push_back(stop[0]);
      bits.push_back(stop[1]);
    end else begin
      bits.push_back(stop[0]);
    end
    bits.push_back(1'b1);
    foreach (bits[i]) drive_bit(which, bits[i]);
  endtask

  // Reference model: entry = {ferr, perr, data}; even parity for receiver b.
  // With model_full, receiver a is assumed not to be draining, so occupancy = queue size.
  task automatic issue(input bit which, input logic [7:0] d, input logic par,
                       input logic [1:0] stop, input bit model_full);
    logic odd_ones;
    odd_ones = ($countones(d) % 2 == 1);
    if (!which) begin
      if (model_full && exp_a.size() >= 4) exp_ovr_a++;
      else exp_a.push_back({~stop[0], 1'b0, d});
    end else begin
      exp_b.push_back({~(stop[0] & stop[1]), (par != odd_ones), d});
    end
    send(which, d, par, stop);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    @(posedge clk);
    #1 rx_ready = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && exp_b.size() == 0 && !valid_a && !valid_b) done = 1'b1;
    end
    check(name, done, 1'b1);
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    logic [7:0] d;
    logic [1:0] st;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_a, 1'b0);
    check("rst_level", level_a, 3'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_outs", {ferr_a, perr_a, data_a, ovr_a}, 11'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single 8N1 frame, then one-cycle read.
    issue(0, 8'hA5, 1'b0, 2'b11, 1'b0);
    @(negedge clk);
    check("t1_valid", valid_a, 1'b1);
    check("t1_head", {ferr_a, perr_a, data_a}, 10'h0A5);
    check("t1_level", level_a, 3'd1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("t1_level_after", level_a, 3'd0);
    check("t1_valid_after", valid_a, 1'b0);
    check("t1_data_empty", data_a, 8'h00);

    // False start: 4-cycle glitch.
    saw_busy = 1'b0;
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    check("t2_busy_rose", saw_busy, 1'b1);
    check("t2_busy_fell", busy_a, 1'b0);
    check("t2_level", level_a, 3'd0);

    // rx_enable low: no start detection at all.
    rx_enable = 1'b0;
    send(0, 8'h00, 1'b0, 2'b11);
    @(negedge clk);
    check("en_off_level", level_a, 3'd0);
    rx_enable = 1'b1;

    // Even parity on receiver b.
    issue(1, 8'h03, 1'b0, 2'b11, 1'b0);
    issue(1, 8'h03, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    check("t3_level", level_b, 3'd2);
    check("t3_head", {ferr_b, perr_b, data_b}, 10'h003);
    drain("t3_drain");

    // Framing error then good frame.
    issue(0, 8'h55, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    check("t4_head", {ferr_a, perr_a, data_a}, 10'h255);
    issue(0, 8'h12, 1'b0, 2'b11, 1'b0);
    drain("t4_drain");

    // Overrun with consumer stalled.
    for (int i = 1; i <= 5; i++) issue(0, 8'(i), 1'b0, 2'b11, 1'b1);
    @(negedge clk);
    check("t5_level", level_a, 3'd4);
    check("t5_overruns", ovr_cnt_a, exp_ovr_a);
    check("t5_one_overrun", ovr_cnt_a, 1);
    drain("t5_drain");

    // Reset during DATA discards the partial frame.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    @(negedge clk);
    check("t6_busy_mid", busy_a, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy_rst", busy_a, 1'b0);
    check("t6_level_rst", level_a, 3'd0);
    repeat (2 * OS) @(posedge clk);
    issue(0, 8'h3C, 1'b0, 2'b11, 1'b0);
    @(negedge clk);
    check("t6_level", level_a, 3'd1);
    drain("t6_drain");

    // Randomised traffic on both receivers with random back-pressure.
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          d  = 8'($urandom);
          st = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
          issue(0, d, 1'b0, st, 1'b0);
        end
      end
      begin
        for (int j = 0; j < 15; j++) begin
          issue(1, 8'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0) ?
                2'($urandom) : 2'b11, 1'b0);
        end
      end
    join
    rand_rdy = 1'b0;
    drain("rand_drain");
    check("rand_ovr_a", ovr_cnt_a, exp_ovr_a);
    check("rand_ovr_b", ovr_cnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
